pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_0020, the exception handler entry PC.
REQ-004 SHALL have parameter WDOG_LIMIT, default 16'd1023, the maximum number of consecutive stall cycles.
REQ-005 SHALL have stallreq_if_i, stallreq_id_i, stallreq_ex_i and stallreq_mem_i, each input, 1, a per-stage hold request.
REQ-006 SHALL have excepttype_i, input, 32, the exception code from the MEM stage; zero means none; 32'h0000_000e means eret.
REQ-007 SHALL have cp0_epc_i, input, 32, the return PC for eret.
REQ-008 SHALL have stall_o, output, 6, per-stage hold vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 means stop.
REQ-009 SHALL have flush_o, output, 1, which clears all pipeline registers.
REQ-010 SHALL have new_pc_o, output, 32, the redirect target, valid while flush_o is 1.
REQ-011 SHALL have wdog_o, output, 1, a sticky flag indicating the stall watchdog has expired.

Function
REQ-012 SHALL use a state machine with states RUN, FLUSH and REFILL.
REQ-013 SHALL, in RUN, drive stall_o combinationally by priority:
- mem request: 6'b011111
- else ex request: 6'b001111
- else id request: 6'b000111
- else if request: 6'b000011
- else 6'b000000
REQ-014 SHALL, in RUN, move to FLUSH on the next edge when excepttype_i != 0, and latch new_pc_o on that edge: cp0_epc_i for eret, else EXC_VECTOR.
REQ-015 SHALL make an exception take priority over every stall request in the same cycle; stall_o is 6'b000000 during that cycle.
REQ-016 SHALL, in FLUSH, hold flush_o at 1 and stall_o at 6'b000000 for exactly one cycle, then move to REFILL.
REQ-017 SHALL, in REFILL, drive stall_o = 6'b000000, ignore excepttype_i, and return to RUN after one cycle.
REQ-018 SHALL keep a 16-bit counter of consecutive RUN cycles with stall_o != 0; it clears on any cycle with stall_o == 0 and saturates at 16'hFFFF.
REQ-019 SHALL set wdog_o when the counter reaches WDOG_LIMIT; wdog_o stays set until reset.
REQ-020 SHALL, once wdog_o sets, force stall_o = 6'b000000 for one cycle and then resume normal priority.
REQ-021 SHALL let stall requests arriving during FLUSH or REFILL have no effect until RUN.

Reset
REQ-022 SHALL, while rst is 0, hold state RUN, stall_o = 6'b000000, flush_o = 0, new_pc_o = 32'h0, counter = 0 and wdog_o = 0.
REQ-023 SHALL let an assertion of rst in FLUSH or REFILL abort the sequence immediately, with no residual flush pulse.
REQ-024 SHALL leave RUN only on the first rising edge after rst returns to 1.

Configuration
REQ-025 SHALL, with macro PIPE_CTRL_PERF_EN defined, add outputs perf_stall_cnt_o (32) and perf_flush_cnt_o (32): free-running totals of stalled cycles and flushes, wrapping at 2^32 and reset to 0.
REQ-026 SHALL, without PIPE_CTRL_PERF_EN, omit those ports and counters entirely.

Structure
REQ-027 SHALL place in the shared defines file:
- stall encodings Stop/NoStop
- stage bit indices
- ERET code 32'h0000_000e
- state encodings
REQ-028 SHALL place the watchdog in one sub-module, pipe_wdog (counter, limit compare, sticky flag); the rest stays flat.

Verification
REQ-029 SHALL verify: stallreq_ex_i=1 and stallreq_id_i=1 for 3 cycles -> stall_o=6'b001111 for those 3 cycles, then 6'b000000.
REQ-030 SHALL verify: excepttype_i=32'h1 with stallreq_mem_i=1 -> that cycle stall_o=0; next cycle flush_o=1, new_pc_o=32'h20; the cycle after flush_o=0.
REQ-031 SHALL verify: excepttype_i=32'he, cp0_epc_i=32'h8000_0100 -> flush_o=1 one cycle with new_pc_o=32'h8000_0100.
REQ-032 SHALL verify: WDOG_LIMIT=8, stallreq_mem_i held at 1 -> wdog_o rises after 8 stalled cycles, stall_o=0 for one cycle, then 6'b011111 again.
REQ-033 SHALL verify: rst=0 asserted mid-FLUSH -> flush_o=0 immediately; after release, state is RUN and all outputs are zero.
REQ-034 SHALL verify, with PIPE_CTRL_PERF_EN: 5 stalled cycles and 2 exceptions -> perf_stall_cnt_o=5, perf_flush_cnt_o=2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall encodings, stage
// indices, the eret exception code and the controller state encoding.
package pipe_ctrl_pkg;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam logic [31:0] ERET_CODE = 32'h0000_000e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2
    } state_t;

    // Hold every stage from the PC up to and including the requesting stage.
    function automatic logic [5:0] hold_upto(input int stg);
        logic [5:0] v;
        for (int i = STG_PC; i <= STG_WB; i++) begin
            v[i] = (i <= stg) ? Stop : NoStop;
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_wdog.sv
// Stall watchdog: counts consecutive stalled cycles, raises a sticky flag at
// LIMIT and requests a single idle (unstalled) cycle when the flag first sets.
module pipe_wdog #(
    parameter logic [15:0] LIMIT = 16'd1023
) (
    input  logic clk,
    input  logic rst,
    input  logic stalled,
    output logic wdog,
    output logic force_idle
);

    logic [15:0] cnt;
    logic [15:0] cnt_next;

    always_comb begin
        cnt_next = 16'd0;
        if (stalled) begin
            cnt_next = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= 16'd0;
            wdog       <= 1'b0;
            force_idle <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            force_idle <= 1'b0;
            if (!wdog && stalled && (cnt_next >= LIMIT)) begin
                wdog       <= 1'b1;
                force_idle <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with exception redirect and stall watchdog.
// Optional performance counters are enabled with macro PIPE_CTRL_PERF_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_RUN    | normal operation, stall vector from per-stage requests
// ST_FLUSH  | one-cycle flush pulse, new_pc_o holds redirect target
// ST_REFILL | one-cycle settle after flush, requests/exceptions ignored
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [15:0] WDOG_LIMIT = 16'd1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        wdog_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);

    state_t     state;
    logic       wdog_force;
    logic       exc_req;
    logic [5:0] stall_req;

    assign exc_req = (state == ST_RUN) && (excepttype_i != 32'd0);

    always_comb begin
        stall_req = {6{NoStop}};
        if (stallreq_mem_i)     stall_req = hold_upto(STG_MEM);
        else if (stallreq_ex_i) stall_req = hold_upto(STG_EX);
        else if (stallreq_id_i) stall_req = hold_upto(STG_ID);
        else if (stallreq_if_i) stall_req = hold_upto(STG_IF);
    end

    // Gated by rst so the hold vector is quiet throughout reset.
    always_comb begin
        stall_o = {6{NoStop}};
        if (rst && (state == ST_RUN) && !exc_req && !wdog_force) begin
            stall_o = stall_req;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            flush_o  <= 1'b0;
            new_pc_o <= 32'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (exc_req) begin
                        state    <= ST_FLUSH;
                        flush_o  <= 1'b1;
                        new_pc_o <= (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                    end
                end
                ST_FLUSH: begin
                    state   <= ST_REFILL;
                    flush_o <= 1'b0;
                end
                ST_REFILL: begin
                    state <= ST_RUN;
                end
                default: begin
                    state   <= ST_RUN;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

    pipe_wdog #(
        .LIMIT(WDOG_LIMIT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .stalled   (stall_o != 6'd0),
        .wdog      (wdog_o),
        .force_idle(wdog_force)
    );

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt_o <= 32'd0;
            perf_flush_cnt_o <= 32'd0;
        end else begin
            if (stall_o != 6'd0) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (exc_req)         perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each cycle's expected outputs are queued
// when the stimulus is driven and compared at the following falling edge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_r = 1'b0, id_r = 1'b0, ex_r = 1'b0, mem_r = 1'b0;
    logic [31:0] exc = 32'd0;
    logic [31:0] epc = 32'd0;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        wdog_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cnt_o;
    logic [31:0] perf_flush_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        wdog;
    } exp_t;

    exp_t sb[$];

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_IF   = 6'b000011;
    localparam logic [5:0] S_ID   = 6'b000111;
    localparam logic [5:0] S_EX   = 6'b001111;
    localparam logic [5:0] S_MEM  = 6'b011111;

    pipe_ctrl #(
        .EXC_VECTOR(32'h0000_0020),
        .WDOG_LIMIT(16'd8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if_i (if_r),
        .stallreq_id_i (id_r),
        .stallreq_ex_i (ex_r),
        .stallreq_mem_i(mem_r),
        .excepttype_i  (exc),
        .cp0_epc_i     (epc),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .new_pc_o      (new_pc_o),
        .wdog_o        (wdog_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt_o(perf_stall_cnt_o),
        .perf_flush_cnt_o(perf_flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // req = {mem, ex, id, if}; pc is only compared while a flush is expected.
    task automatic cyc(input string tag, input logic [3:0] req, input logic [31:0] e,
                       input logic [5:0] x_stall, input logic x_flush,
                       input logic [31:0] x_pc, input logic x_wdog);
        exp_t x;
        @(posedge clk);
        #1;
        {mem_r, ex_r, id_r, if_r} = req;
        exc     = e;
        x.stall = x_stall;
        x.flush = x_flush;
        x.pc    = x_pc;
        x.wdog  = x_wdog;
        sb.push_back(x);
        @(negedge clk);
        x = sb.pop_front();
        chk({tag, ".stall"}, 32'(stall_o), 32'(x.stall));
        chk({tag, ".flush"}, 32'(flush_o), 32'(x.flush));
        chk({tag, ".wdog"},  32'(wdog_o),  32'(x.wdog));
        if (x.flush) chk({tag, ".new_pc"}, new_pc_o, x.pc);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        mem_r = 1'b1;
        exc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ".rst_stall"}, 32'(stall_o), 32'(S_NONE));
        chk({tag, ".rst_flush"}, 32'(flush_o), 32'd0);
        chk({tag, ".rst_pc"},    new_pc_o,     32'd0);
        chk({tag, ".rst_wdog"},  32'(wdog_o),  32'd0);
        {mem_r, ex_r, id_r, if_r} = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        do_reset("init");

        // ex+id priority for three cycles, then release
        cyc("exid1", 4'b0110, 32'd0, S_EX, 1'b0, 32'd0, 1'b0);
        cyc("exid2", 4'b0110, 32'd0, S_EX, 1'b0, 32'd0, 1'b0);
        cyc("exid3", 4'b0110, 32'd0, S_EX, 1'b0, 32'd0, 1'b0);
        cyc("idle1", 4'b0000, 32'd0, S_NONE, 1'b0, 32'd0, 1'b0);
        cyc("if",    4'b0001, 32'd0, S_IF,   1'b0, 32'd0, 1'b0);
        cyc("id_if", 4'b0011, 32'd0, S_ID,   1'b0, 32'd0, 1'b0);
        cyc("all",   4'b1111, 32'd0, S_MEM,  1'b0, 32'd0, 1'b0);
        cyc("idle2", 4'b0000, 32'd0, S_NONE, 1'b0, 32'd0, 1'b0);

        // exception over mem stall; exception during REFILL is ignored
        cyc("exc",    4'b1000, 32'h1,  S_NONE, 1'b0, 32'd0,  1'b0);
        cyc("flush",  4'b1000, 32'h0,  S_NONE, 1'b1, 32'h20, 1'b0);
        cyc("refill", 4'b1000, 32'h1,  S_NONE, 1'b0, 32'd0,  1'b0);
        cyc("run",    4'b1000, 32'h0,  S_MEM,  1'b0, 32'd0,  1'b0);
        cyc("idle3",  4'b0000, 32'h0,  S_NONE, 1'b0, 32'd0,  1'b0);

        // eret redirects to cp0 epc
        epc = 32'h8000_0100;
        cyc("eret",   4'b0000, 32'he, S_NONE, 1'b0, 32'd0,         1'b0);
        cyc("eflush", 4'b0100, 32'h0, S_NONE, 1'b1, 32'h8000_0100, 1'b0);
        cyc("erefil", 4'b0100, 32'h0, S_NONE, 1'b0, 32'd0,         1'b0);
        cyc("erun",   4'b0100, 32'h0, S_EX,   1'b0, 32'd0,         1'b0);
        cyc("idle4",  4'b0000, 32'h0, S_NONE, 1'b0, 32'd0,         1'b0);

        // reset asserted mid-FLUSH aborts the pulse at once
        cyc("rexc", 4'b0000, 32'h4, S_NONE, 1'b0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        exc = 32'd0;
        chk("rflush_on", 32'(flush_o), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rabort_flush", 32'(flush_o), 32'd0);
        chk("rabort_stall", 32'(stall_o), 32'(S_NONE));
        chk("rabort_pc",    new_pc_o,     32'd0);
        chk("rabort_wdog",  32'(wdog_o),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc("rpost", 4'b0000, 32'h0, S_NONE, 1'b0, 32'd0, 1'b0);
        chk("rpost_pc", new_pc_o, 32'd0);
        cyc("rrun",  4'b1000, 32'h0, S_MEM,  1'b0, 32'd0, 1'b0);
        cyc("ridle", 4'b0000, 32'h0, S_NONE, 1'b0, 32'd0, 1'b0);

`ifdef PIPE_CTRL_PERF_EN
        do_reset("perf");
        for (int i = 0; i < 5; i++) cyc("pstall", 4'b0001, 32'h0, S_IF, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc("pexc",    4'b0000, 32'h2, S_NONE, 1'b0, 32'd0,  1'b0);
            cyc("pflush",  4'b0000, 32'h0, S_NONE, 1'b1, 32'h20, 1'b0);
            cyc("prefill", 4'b0000, 32'h0, S_NONE, 1'b0, 32'd0,  1'b0);
        end
        chk("perf_stall", perf_stall_cnt_o, 32'd5);
        chk("perf_flush", perf_flush_cnt_o, 32'd2);
`endif

        // watchdog: 8 stalled cycles, one forced idle cycle, then stall again
        do_reset("wd");
        for (int i = 0; i < 8; i++) cyc("wd_stall", 4'b1000, 32'h0, S_MEM, 1'b0, 32'd0, 1'b0);
        cyc("wd_idle",  4'b1000, 32'h0, S_NONE, 1'b0, 32'd0, 1'b1);
        cyc("wd_again", 4'b1000, 32'h0, S_MEM,  1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 10; i++) cyc("wd_hold", 4'b1000, 32'h0, S_MEM, 1'b0, 32'd0, 1'b1);
        cyc("wd_rel", 4'b0000, 32'h0, S_NONE, 1'b0, 32'd0, 1'b1);
        do_reset("wd_clr");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
